// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives the data-memory handshake, stalls the front of the
// pipeline while an access is outstanding, and owns the MEM/WB pipeline register.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iPC,
    input  logic [31:0] iIR,
    input  logic [31:0] ialu_res,
    input  logic [31:0] iRS2,
    input  logic [4:0]  iwrite_addr,
    input  logic        imem_read,
    input  logic        imem_write,
    input  logic        imem_to_reg,
    input  logic        ipc_to_reg,
    input  logic        ireg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] oPC,
    output logic [31:0] oIR,
    output logic [31:0] oalu_res,
    output logic [31:0] omem_data,
    output logic [4:0]  owrite_addr,
    output logic        omem_to_reg,
    output logic        opc_to_reg,
    output logic        oreg_write,
    output logic        oexc_align,
    output logic        oexc_bus
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_cmd_t;

    // Counter value seen during the last allowed WAIT cycle (counter starts at 0).
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t    state;
    logic [7:0] wait_cnt;
    dmem_cmd_t held;
    dmem_cmd_t cur;

    logic access, aligned, misalign, abort, ld_done;

    always_comb begin
        access   = imem_read | imem_write;
        aligned  = (ialu_res[1:0] == 2'b00);
        misalign = 1'b0;
        cur      = '0;
        dmem_req = 1'b0;
        if (state == S_WAIT) begin
            cur      = held;
            dmem_req = ~reset;
        end else begin
            cur      = '{we: imem_write, addr: ialu_res, wdata: iRS2};
            dmem_req = access & aligned & ~reset;
            misalign = access & ~aligned & ~reset;
        end
        abort   = (state == S_WAIT) & dmem_req & ~dmem_ready & (wait_cnt == TO_LAST);
        stall   = dmem_req & ~dmem_ready & ~abort;
        ld_done = dmem_req & dmem_ready & ~cur.we;
    end

    assign dmem_we    = cur.we;
    assign dmem_addr  = cur.addr;
    assign dmem_wdata = cur.wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            held        <= '0;
            oPC         <= '0;
            oIR         <= '0;
            oalu_res    <= '0;
            omem_data   <= '0;
            owrite_addr <= '0;
            omem_to_reg <= 1'b0;
            opc_to_reg  <= 1'b0;
            oreg_write  <= 1'b0;
            oexc_align  <= 1'b0;
            oexc_bus    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dmem_req && !dmem_ready) begin
                        state    <= S_WAIT;
                        held     <= cur;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (dmem_ready || abort) state <= S_IDLE;
                    else                     wait_cnt <= wait_cnt + 8'd1;
                end
                default: state <= S_IDLE;
            endcase

            oexc_align <= misalign;
            oexc_bus   <= abort;

            if (stall) begin
                // Bubble: kill the writeback, keep the data fields.
                oIR         <= '0;
                oreg_write  <= 1'b0;
                omem_to_reg <= 1'b0;
                opc_to_reg  <= 1'b0;
            end else begin
                oPC         <= iPC;
                oIR         <= iIR;
                oalu_res    <= ialu_res;
                owrite_addr <= iwrite_addr;
                omem_to_reg <= imem_to_reg;
                opc_to_reg  <= ipc_to_reg;
                oreg_write  <= ireg_write & ~misalign & ~abort;
                if (ld_done) omem_data <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: ALU pass-through, wait-state load, zero-wait
// store, misalignment, timeout abort and reset during WAIT.
module tb_mem_stage_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iPC, iIR, ialu_res, iRS2;
    logic [4:0]  iwrite_addr;
    logic        imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] oPC, oIR, oalu_res, omem_data;
    logic [4:0]  owrite_addr;
    logic        omem_to_reg, opc_to_reg, oreg_write, oexc_align, oexc_bus;

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .iPC(iPC), .iIR(iIR), .ialu_res(ialu_res), .iRS2(iRS2),
        .iwrite_addr(iwrite_addr),
        .imem_read(imem_read), .imem_write(imem_write), .imem_to_reg(imem_to_reg),
        .ipc_to_reg(ipc_to_reg), .ireg_write(ireg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall),
        .oPC(oPC), .oIR(oIR), .oalu_res(oalu_res), .omem_data(omem_data),
        .owrite_addr(owrite_addr), .omem_to_reg(omem_to_reg), .opc_to_reg(opc_to_reg),
        .oreg_write(oreg_write), .oexc_align(oexc_align), .oexc_bus(oexc_bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        iPC = '0; iIR = '0; ialu_res = '0; iRS2 = '0; iwrite_addr = '0;
        imem_read = 0; imem_write = 0; imem_to_reg = 0; ipc_to_reg = 0; ireg_write = 0;
        dmem_ready = 0; dmem_rdata = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick(); tick();
        chk("rst_oreg_write", 32'(oreg_write), 32'd0);
        chk("rst_oalu_res", oalu_res, 32'd0);
        chk("rst_exc", {30'd0, oexc_align, oexc_bus}, 32'd0);
        // Aligned load presented while reset is held must not request.
        imem_read = 1; ialu_res = 32'h80; #1;
        chk("rst_req_comb", 32'(dmem_req), 32'd0);
        chk("rst_stall_comb", 32'(stall), 32'd0);
        idle_inputs();
        reset = 0;
        tick();

        // ALU op, no memory access
        iPC = 32'h40; iIR = 32'h13; ialu_res = 32'h1234; iwrite_addr = 5'd5; ireg_write = 1; #1;
        chk("alu_req", 32'(dmem_req), 32'd0);
        chk("alu_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_oalu_res", oalu_res, 32'h1234);
        chk("alu_oreg_write", 32'(oreg_write), 32'd1);
        chk("alu_owrite_addr", 32'(owrite_addr), 32'd5);
        chk("alu_oPC", oPC, 32'h40);
        chk("alu_oIR", oIR, 32'h13);

        // Load 0x100, ready three cycles after request
        iPC = 32'h44; iIR = 32'h2003; ialu_res = 32'h100; iwrite_addr = 5'd6;
        imem_read = 1; imem_to_reg = 1; ireg_write = 1; #1;
        chk("ld_req", 32'(dmem_req), 32'd1);
        chk("ld_we", 32'(dmem_we), 32'd0);
        chk("ld_addr", dmem_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall", 32'(stall), 32'd1);
            tick();
            chk("ld_bubble_wr", 32'(oreg_write), 32'd0);
            chk("ld_bubble_ir", oIR, 32'd0);
            if (i == 0) ialu_res = 32'h999;  // captured address must be driven in WAIT
            if (i == 1) begin
                chk("ld_held_addr", dmem_addr, 32'h100);
                ialu_res = 32'h100;
            end
        end
        dmem_ready = 1; dmem_rdata = 32'hDEADBEEF; #1;
        chk("ld_done_stall", 32'(stall), 32'd0);
        chk("ld_done_req", 32'(dmem_req), 32'd1);
        tick();
        chk("ld_omem_data", omem_data, 32'hDEADBEEF);
        chk("ld_omem_to_reg", 32'(omem_to_reg), 32'd1);
        chk("ld_oreg_write", 32'(oreg_write), 32'd1);
        chk("ld_oIR", oIR, 32'h2003);

        // Store 0x200, zero-wait
        idle_inputs();
        ialu_res = 32'h200; iRS2 = 32'hCAFEF00D; imem_write = 1; imem_read = 1;
        dmem_ready = 1; dmem_rdata = 32'h11111111; #1;
        chk("st_req", 32'(dmem_req), 32'd1);
        chk("st_we", 32'(dmem_we), 32'd1);
        chk("st_wdata", dmem_wdata, 32'hCAFEF00D);
        chk("st_stall", 32'(stall), 32'd0);
        tick();
        idle_inputs(); #1;
        chk("st_no_wait", 32'(dmem_req), 32'd0);
        chk("st_omem_hold", omem_data, 32'hDEADBEEF);

        // Misaligned load 0x102
        ialu_res = 32'h102; imem_read = 1; imem_to_reg = 1; ireg_write = 1; #1;
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        tick();
        chk("mis_exc", 32'(oexc_align), 32'd1);
        chk("mis_oreg_write", 32'(oreg_write), 32'd0);
        idle_inputs();
        tick();
        chk("mis_exc_pulse", 32'(oexc_align), 32'd0);

        // Timeout abort with TIMEOUT=4
        ialu_res = 32'h300; imem_read = 1; imem_to_reg = 1; ireg_write = 1;
        dmem_rdata = 32'h55555555; #1;
        for (int i = 0; i < 4; i++) begin
            chk("to_stall", 32'(stall), 32'd1);
            tick();
        end
        chk("to_abort_stall", 32'(stall), 32'd0);
        chk("to_abort_req", 32'(dmem_req), 32'd1);
        tick();
        chk("to_exc_bus", 32'(oexc_bus), 32'd1);
        chk("to_oreg_write", 32'(oreg_write), 32'd0);
        chk("to_omem_hold", omem_data, 32'hDEADBEEF);
        idle_inputs(); #1;
        chk("to_idle", 32'(dmem_req), 32'd0);
        tick();
        chk("to_exc_pulse", 32'(oexc_bus), 32'd0);

        // Reset during the second WAIT cycle
        iPC = 32'h60; ialu_res = 32'h400; imem_read = 1; ireg_write = 1;
        tick(); tick();
        chk("rw_in_wait", 32'(stall), 32'd1);
        reset = 1; #1;
        chk("rw_req_comb", 32'(dmem_req), 32'd0);
        tick();
        reset = 0;
        idle_inputs(); #1;
        chk("rw_req", 32'(dmem_req), 32'd0);
        chk("rw_stall", 32'(stall), 32'd0);
        chk("rw_omem", omem_data, 32'd0);
        chk("rw_oPC", oPC, 32'd0);
        chk("rw_oalu", oalu_res, 32'd0);
        ialu_res = 32'h500; imem_read = 1; imem_to_reg = 1; ireg_write = 1;
        dmem_ready = 1; dmem_rdata = 32'h12345678; #1;
        chk("rw_ld_stall", 32'(stall), 32'd0);
        tick();
        chk("rw_ld_data", omem_data, 32'h12345678);
        chk("rw_ld_wr", 32'(oreg_write), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max WAIT-state cycles before a data-memory access is aborted (1..255).
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 iPC, iIR, ialu_res, iRS2  in  32 each  EX/MEM pipeline-register contents; ialu_res = byte address, iRS2 = store data.
REQ-005 iwrite_addr  in  5  destination register.
REQ-006 imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write  in  1 each  EX/MEM control bits.
REQ-007 dmem_req  out  1  data-memory request, level, held until dmem_ready or abort.
REQ-008 dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
REQ-009 dmem_addr, dmem_wdata  out  32 each  access address / store data; valid with dmem_req.
REQ-010 dmem_ready  in  1  access complete this cycle; dmem_rdata valid when load.
REQ-011 dmem_rdata  in  32  load data.
REQ-012 stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 oPC, oIR, oalu_res, omem_data  out  32 each  MEM/WB register outputs.
REQ-014 owrite_addr  out  5; omem_to_reg, opc_to_reg, oreg_write  out  1 each  MEM/WB register outputs.
REQ-015 oexc_align, oexc_bus  out  1 each  one-cycle pulses: misaligned access / timeout abort.

Function
REQ-016 Access = imem_read | imem_write; both set: store, load ignored.
REQ-017 Aligned = ialu_res[1:0] == 2'b00; word accesses only.
REQ-018 FSM states IDLE, WAIT; reset state IDLE.
REQ-019 IDLE, aligned access: dmem_req=1 combinationally same cycle, dmem_addr=ialu_res, dmem_wdata=iRS2, dmem_we=imem_write.
REQ-020 IDLE, dmem_req with dmem_ready=1 same cycle: zero-wait completion, stall=0, state stays IDLE.
REQ-021 IDLE, dmem_req with dmem_ready=0: go WAIT; addr/wdata/we captured into internal registers, driven from them while in WAIT.
REQ-022 stall = dmem_req & ~dmem_ready & ~abort, combinational.
REQ-023 WAIT: dmem_req=1; dmem_ready=1 -> complete, go IDLE.
REQ-024 WAIT: wait counter cleared on entry, +1 per WAIT cycle; counter reaching TIMEOUT with dmem_ready=0 -> abort: dmem_req stays 1 that cycle, stall=0, oexc_bus pulse next cycle, go IDLE.
REQ-025 MEM/WB load on every cycle with stall=0: oPC, oIR, oalu_res, owrite_addr, omem_to_reg, opc_to_reg <= inputs; oreg_write <= ireg_write.
REQ-026 omem_data <= dmem_rdata on load completion; otherwise holds previous value.
REQ-027 Stall cycles: MEM/WB receives bubble -- oIR=0, oreg_write=0, omem_to_reg=0, opc_to_reg=0; other outputs hold.
REQ-028 Misaligned access: no dmem_req, stall=0, oexc_align=1 next cycle, oreg_write<=0 for that instruction.
REQ-029 Abort: oreg_write<=0 for that instruction.
REQ-030 No access: pure one-cycle register, latency 1, dmem_req=0.
REQ-031 dmem_rdata ignored except load completion; dmem_ready ignored while dmem_req=0.

Reset
REQ-032 reset=1 at posedge: state IDLE, wait counter 0, all MEM/WB outputs and oexc_* = 0.
REQ-033 Reset during WAIT abandons the access; dmem_req=0 and stall=0 from the cycle after the reset edge.
REQ-034 While reset=1: dmem_req=0 and stall=0 combinationally.

Verification
REQ-035 ALU op, ialu_res=0x1234, ireg_write=1, no access -> next cycle oalu_res=0x1234, oreg_write=1, stall never 1.
REQ-036 Load addr 0x100, dmem_ready 3 cycles after req, rdata=0xDEADBEEF -> stall=1 for 3 cycles, 3 bubbles (oreg_write=0), then omem_data=0xDEADBEEF, omem_to_reg=1, oreg_write=1.
REQ-037 Store addr 0x200, iRS2=0xCAFEF00D, dmem_ready same cycle -> dmem_we=1, dmem_wdata=0xCAFEF00D, stall=0, no WAIT entry.
REQ-038 Load addr 0x102 -> dmem_req=0, next cycle oexc_align=1, oreg_write=0.
REQ-039 TIMEOUT=4, load, dmem_ready held 0 -> abort on 4th WAIT cycle, oexc_bus=1 one cycle, oreg_write=0, FSM IDLE.
REQ-040 reset=1 during second WAIT cycle -> next cycle dmem_req=0, stall=0, all outputs 0; next load after reset completes normally.
